// File: rtl/suma_bcd_converter.sv
// suma_bcd_converter: iterative double-dabble conversion of the adder result {cout, suma}
// into packed BCD digits, one bit per cycle, with a one-cycle done pulse.
module suma_bcd_converter #(
    parameter int Width  = 4,
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                cout,
    input  logic [Width-1:0]    suma,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                overflow
);
    localparam int CW = $clog2(Width + 2);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state;
    logic [Width:0]      bin;
    logic [Width:0]      value;
    logic [4*DIGITS-1:0] scratch;
    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] next_scratch;
    logic [CW-1:0]       cnt;
    logic                ovf_pend;

    assign value = {cout, suma};

    // Digits carried past the top nibble are dropped, leaving value mod 10^DIGITS.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = (scratch[4*i +: 4] >= 4'd5) ? scratch[4*i +: 4] + 4'd3 : scratch[4*i +: 4];
        next_scratch = {adj[4*DIGITS-2:0], bin[Width]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bin      <= '0;
            scratch  <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        bin      <= value;
                        scratch  <= '0;
                        cnt      <= CW'(Width + 1);
                        ovf_pend <= 64'(value) > MAX_VAL;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= next_scratch;
                    bin     <= bin << 1;
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        bcd      <= next_scratch;
                        overflow <= ovf_pend;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
